advtim_cap_mch: RTL and testbench

- Multi-channel, parametrised input-capture engine for the advance timer; the next generation after the single-channel capture counter.
- One shared prescaler feeds CH_NUM independent capture channels.
- Each channel has its own edge polarity, PWM/step mode, tick/wrap duration counters, period-repeat count and done status.
- Sits in advtim_pe_core beside the PWM generators; drives the capture result registers and interrupt status.

---
 rtl/advtim_cap_mch.sv | 225 ++++++++++++++++++++++
 tb/tb_advtim_cap_mch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/advtim_cap_mch.sv
// Multi-channel input-capture engine: one shared prescaler, per-channel edge FSM with tick/wrap counters.
// Define ADVTIM_CAP_FILTER_EN to add a FILT_LEN-sample glitch filter on every cap_in.
//
// state | meaning
// IDLE  | not capturing; waits for armed start edge
// HIGH  | measuring active width, waits for end edge
// LOW   | PWM: measuring rest of period, waits for next start edge
// WAIT  | step: width captured, waits for next start edge
// DONE  | r_rcr periods captured; holds until clear/disable
module advtim_cap_mch #(
   parameter int CH_NUM   = 4,
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 4
) (
   input  logic                    pe_cap_clk,
   input  logic                    pe_cap_rst,
   input  logic                    pe_cap_tim_enable,
   input  logic                    pe_cap_logic_clr,
   input  logic [CNT_W-1:0]        r_psc,
   input  logic [CNT_W-1:0]        r_arr,
   input  logic [CNT_W-1:0]        r_rcr,
   input  logic [CH_NUM-1:0]       r_ch_en,
   input  logic [CH_NUM-1:0]       r_ic_pol,
   input  logic [CH_NUM-1:0]       r_ic_mode,
   input  logic [CH_NUM-1:0]       cap_in,
   output logic [CH_NUM*CNT_W-1:0] cap_hi_arr,
   output logic [CH_NUM*CNT_W-1:0] cap_hi_rcr,
   output logic [CH_NUM*CNT_W-1:0] cap_per_arr,
   output logic [CH_NUM*CNT_W-1:0] cap_per_rcr,
   output logic [CH_NUM-1:0]       cap_valid,
   output logic [CH_NUM-1:0]       cap_ovf,
   output logic [CH_NUM-1:0]       ch_done,
   output logic                    pe_cap_tim_end,
   output logic [CH_NUM-1:0]       int_status_cap_reloaded,
   output logic                    int_status_cap_end
);

   typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_WAIT, S_DONE} ch_state_t;

   localparam logic [CNT_W-1:0] W_MAX = '1;

   logic             en_q, armed, end_q;
   logic             en_rise, run, tick;
   logic [CNT_W-1:0] psc_s, arr_s, rcr_s, psc_cnt, psc_last, arr_last;
   logic [CH_NUM-1:0] cap_lvl, valid_v, ovf_v, done_v;

   assign en_rise  = pe_cap_tim_enable & ~en_q;
   assign run      = pe_cap_tim_enable & en_q;
   assign psc_last = (psc_s == '0) ? '0 : psc_s - CNT_W'(1);
   assign arr_last = arr_s - CNT_W'(1);
   assign tick     = run & (psc_cnt == psc_last);

   always_ff @(posedge pe_cap_clk) begin
      if (pe_cap_rst) begin
         en_q    <= 1'b0;
         armed   <= 1'b0;
         end_q   <= 1'b0;
         psc_cnt <= '0;
         psc_s   <= CNT_W'(1);
         arr_s   <= '0;
         rcr_s   <= '0;
      end else begin
         en_q  <= pe_cap_tim_enable;
         end_q <= pe_cap_tim_end;
         if (pe_cap_logic_clr || en_rise) begin
            psc_s <= r_psc;
            arr_s <= r_arr;
            rcr_s <= r_rcr;
         end
         if (pe_cap_logic_clr || !pe_cap_tim_enable) armed <= 1'b0;
         else if (en_rise)                           armed <= 1'b1;
         if (pe_cap_logic_clr || !run || tick) psc_cnt <= '0;
         else                                  psc_cnt <= psc_cnt + CNT_W'(1);
      end
   end

`ifdef ADVTIM_CAP_FILTER_EN
   localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   for (genvar g = 0; g < CH_NUM; g++) begin : g_filt
      logic [FC_W-1:0] f_cnt;
      logic            lvl;
      always_ff @(posedge pe_cap_clk) begin
         if (pe_cap_rst) begin
            f_cnt <= '0;
            lvl   <= 1'b0;
         end else if (cap_in[g] == lvl) begin
            f_cnt <= '0;
         end else if (f_cnt == FC_W'(FILT_LEN - 1)) begin
            f_cnt <= '0;
            lvl   <= cap_in[g];
         end else begin
            f_cnt <= f_cnt + FC_W'(1);
         end
      end
      assign cap_lvl[g] = lvl;
   end
`else
   assign cap_lvl = cap_in;
   if (FILT_LEN < 1) begin : g_no_filt
   end
`endif

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      ch_state_t        st, st_n;
      logic             prev, start_e, end_e, last, counting;
      logic             restart, lat_hi, lat_per, per_inc, valid_n;
      logic             valid, ovf;
      logic [CNT_W-1:0] t_cnt, w_cnt, per_cnt, hi_arr, hi_rcr, per_arr, per_rcr;

      assign start_e  = r_ic_pol[i] ? (prev & ~cap_lvl[i]) : (~prev & cap_lvl[i]);
      assign end_e    = r_ic_pol[i] ? (~prev & cap_lvl[i]) : (prev & ~cap_lvl[i]);
      assign last     = (rcr_s != '0) && ((per_cnt + CNT_W'(1)) == rcr_s);
      assign counting = (st == S_HIGH) || (st == S_LOW);

      always_comb begin
         st_n    = st;
         restart = 1'b0;
         lat_hi  = 1'b0;
         lat_per = 1'b0;
         per_inc = 1'b0;
         valid_n = 1'b0;
         if (!pe_cap_tim_enable || !r_ch_en[i]) begin
            st_n = S_IDLE;
         end else begin
            case (st)
               S_IDLE: if (armed && start_e) begin
                  st_n    = S_HIGH;
                  restart = 1'b1;
               end
               S_HIGH: if (end_e) begin
                  lat_hi = 1'b1;
                  if (r_ic_mode[i]) begin
                     st_n = S_LOW;
                  end else begin
                     per_inc = 1'b1;
                     valid_n = 1'b1;
                     st_n    = last ? S_DONE : S_WAIT;
                  end
               end
               S_LOW: if (start_e) begin
                  lat_per = 1'b1;
                  per_inc = 1'b1;
                  valid_n = 1'b1;
                  restart = 1'b1;
                  st_n    = last ? S_DONE : S_HIGH;
               end
               S_WAIT: if (start_e) begin
                  st_n    = S_HIGH;
                  restart = 1'b1;
               end
               S_DONE:  st_n = S_DONE;
               default: st_n = S_IDLE;
            endcase
         end
      end

      always_ff @(posedge pe_cap_clk) begin
         if (pe_cap_rst) begin
            st      <= S_IDLE;
            prev    <= 1'b0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
            t_cnt   <= '0;
            w_cnt   <= '0;
            per_cnt <= '0;
            hi_arr  <= '0;
            hi_rcr  <= '0;
            per_arr <= '0;
            per_rcr <= '0;
         end else begin
            prev <= cap_lvl[i];
            if (pe_cap_logic_clr) begin
               st      <= S_IDLE;
               valid   <= 1'b0;
               ovf     <= 1'b0;
               t_cnt   <= '0;
               w_cnt   <= '0;
               per_cnt <= '0;
            end else begin
               st    <= st_n;
               valid <= valid_n;
               if (lat_hi) begin
                  hi_arr <= t_cnt;
                  hi_rcr <= w_cnt;
               end
               if (lat_per) begin
                  per_arr <= t_cnt;
                  per_rcr <= w_cnt;
               end
               if (st_n == S_IDLE)                per_cnt <= '0;
               else if (per_inc && rcr_s != '0)   per_cnt <= per_cnt + CNT_W'(1);
               // a start edge restarts the measurement and swallows a coincident tick
               if (restart || !counting || st_n == S_IDLE) begin
                  t_cnt <= '0;
                  w_cnt <= '0;
               end else if (tick) begin
                  if (t_cnt == arr_last) begin
                     t_cnt <= '0;
                     if (w_cnt != W_MAX)             w_cnt <= w_cnt + CNT_W'(1);
                     if (w_cnt >= W_MAX - CNT_W'(1)) ovf   <= 1'b1;
                  end else begin
                     t_cnt <= t_cnt + CNT_W'(1);
                  end
               end
            end
         end
      end

      assign cap_hi_arr[i*CNT_W +: CNT_W]  = hi_arr;
      assign cap_hi_rcr[i*CNT_W +: CNT_W]  = hi_rcr;
      assign cap_per_arr[i*CNT_W +: CNT_W] = per_arr;
      assign cap_per_rcr[i*CNT_W +: CNT_W] = per_rcr;
      assign valid_v[i] = valid;
      assign ovf_v[i]   = ovf;
      assign done_v[i]  = (st == S_DONE);
   end

   assign cap_valid               = valid_v;
   assign cap_ovf                 = ovf_v;
   assign ch_done                 = done_v;
   assign int_status_cap_reloaded = valid_v;
   assign pe_cap_tim_end          = (r_ch_en != '0) && ((done_v | ~r_ch_en) == {CH_NUM{1'b1}});
   assign int_status_cap_end      = pe_cap_tim_end & ~end_q;

endmodule

// File: tb/tb_advtim_cap_mch.sv
// Scoreboard bench for advtim_cap_mch: stimulus pushes expected captures, a negedge monitor pops them on cap_valid.
`timescale 1ns/1ps
module tb_advtim_cap_mch;
   localparam int CH = 4;
   localparam int W  = 16;
`ifdef ADVTIM_CAP_FILTER_EN
   localparam int FD = 4;
`else
   localparam int FD = 0;
`endif

   logic          clk = 1'b0;
   logic          rst, en, clr;
   logic [W-1:0]  psc, arr, rcr;
   logic [CH-1:0] ch_en, pol, mode, cap_in;
   logic [CH*W-1:0] hi_arr, hi_rcr, per_arr, per_rcr;
   logic [CH-1:0] valid, ovf, done, reloaded;
   logic          tim_end, int_end;

   always #5 clk = ~clk;

   advtim_cap_mch #(.CH_NUM(CH), .CNT_W(W), .FILT_LEN(4)) dut (
      .pe_cap_clk(clk), .pe_cap_rst(rst), .pe_cap_tim_enable(en), .pe_cap_logic_clr(clr),
      .r_psc(psc), .r_arr(arr), .r_rcr(rcr), .r_ch_en(ch_en), .r_ic_pol(pol), .r_ic_mode(mode),
      .cap_in(cap_in), .cap_hi_arr(hi_arr), .cap_hi_rcr(hi_rcr), .cap_per_arr(per_arr),
      .cap_per_rcr(per_rcr), .cap_valid(valid), .cap_ovf(ovf), .ch_done(done),
      .pe_cap_tim_end(tim_end), .int_status_cap_reloaded(reloaded), .int_status_cap_end(int_end)
   );

   typedef struct {
      int         ch;
      bit         chk_per;
      logic [W-1:0] ha, hr, pa, pr;
   } exp_t;

   exp_t          sb[$];
   logic [CH-1:0] vhist[$];
   int n_chk = 0, n_fail = 0, n_int_end = 0, nie;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // returns one cycle after the enable rising edge, i.e. the first armed cycle
   task automatic setup(input logic [W-1:0] p, input logic [W-1:0] a, input logic [W-1:0] r,
                        input logic [CH-1:0] e, input logic [CH-1:0] po,
                        input logic [CH-1:0] mo, input logic [CH-1:0] ci);
      en = 1'b0; psc = p; arr = a; rcr = r; ch_en = e; pol = po; mode = mo; cap_in = ci;
      step(6);
      en = 1'b1;
      step(1);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
         if (int_end) n_int_end++;
         if (valid != '0) begin
            vhist.push_back(valid);
            chk("reloaded_eq_valid", 64'(reloaded), 64'(valid));
         end
         for (int i = 0; i < CH; i++) begin
            if (valid[i]) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_valid: got cap_valid on ch%0d, expected none", i);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("sb_ch%0d_id", i), 64'(i), 64'(e.ch));
                  chk($sformatf("ch%0d_hi_arr", i), 64'(hi_arr[i*W +: W]), 64'(e.ha));
                  chk($sformatf("ch%0d_hi_rcr", i), 64'(hi_rcr[i*W +: W]), 64'(e.hr));
                  if (e.chk_per) begin
                     chk($sformatf("ch%0d_per_arr", i), 64'(per_arr[i*W +: W]), 64'(e.pa));
                     chk($sformatf("ch%0d_per_rcr", i), 64'(per_rcr[i*W +: W]), 64'(e.pr));
                  end
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; psc = '0; arr = '0; rcr = '0;
      ch_en = '0; pol = '0; mode = '0; cap_in = '0;
      step(3);
      rst = 1'b0;
      step(1);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_tim_end", 64'(tim_end), 64'd0);
      chk("rst_int_end", 64'(int_end), 64'd0);
      chk("rst_hi_arr", 64'(hi_arr), 64'd0);
      chk("rst_per_rcr", 64'(per_rcr), 64'd0);

      // PWM ch0: psc=2 ticks land on odd offsets from the start edge -> 20 ticks high, 50 per period
      setup(16'd2, 16'd50, 16'd3, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
      nie = n_int_end;
      repeat (3) sb.push_back('{0, 1'b1, 16'd20, 16'd0, 16'd0, 16'd1});
      repeat (3) begin
         cap_in[0] = 1'b1; step(40);
         cap_in[0] = 1'b0; step(60);
      end
      cap_in[0] = 1'b1;
      step(3 + FD);
      chk("pwm_done", 64'(done), 64'b0001);
      chk("pwm_tim_end", 64'(tim_end), 64'd1);
      chk("pwm_int_end_pulses", 64'(n_int_end - nie), 64'd1);

      // step ch1, falling polarity: ticks exclude the start-edge cycle, so 26 clk low -> 25 ticks
      setup(16'd1, 16'd10, 16'd0, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
      chk("done_clr_by_enable_low", 64'(done), 64'd0);
      repeat (3) sb.push_back('{1, 1'b0, 16'd5, 16'd2, 16'd0, 16'd0});
      repeat (3) begin
         cap_in[1] = 1'b0; step(26);
         cap_in[1] = 1'b1; step(14);
      end
      step(2);
      chk("step_never_done", 64'(done), 64'd0);
      chk("step_no_tim_end", 64'(tim_end), 64'd0);

      // ch2 held high: wrap counter saturates, ovf sticky until logic_clr
      setup(16'd1, 16'd1, 16'd0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
      cap_in[2] = 1'b1;
      step(65530 + FD);
      chk("ovf_not_yet", 64'(ovf[2]), 64'd0);
      step(10);
      chk("ovf_set", 64'(ovf[2]), 64'd1);
      sb.push_back('{2, 1'b0, 16'd0, 16'hFFFF, 16'd0, 16'd0});
      cap_in[2] = 1'b0;
      step(5 + FD);
      chk("ovf_sticky", 64'(ovf[2]), 64'd1);
      clr = 1'b1; step(1); clr = 1'b0; step(1);
      chk("ovf_cleared", 64'(ovf), 64'd0);
      chk("clr_holds_hi_rcr2", 64'(hi_rcr[2*W +: W]), 64'hFFFF);

      // logic_clr mid-HIGH on ch0: later edges must not capture until re-armed
      setup(16'd1, 16'd100, 16'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
      cap_in[0] = 1'b1; step(10);
      clr = 1'b1; step(1); clr = 1'b0; step(1);
      cap_in[0] = 1'b0; step(8);
      cap_in[0] = 1'b1; step(8);
      cap_in[0] = 1'b0; step(8 + FD);
      chk("clr_hold_hi_arr0", 64'(hi_arr[W-1:0]), 64'd20);
      chk("clr_hold_per_rcr0", 64'(per_rcr[W-1:0]), 64'd1);
      setup(16'd1, 16'd100, 16'd0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
      sb.push_back('{0, 1'b1, 16'd7, 16'd0, 16'd12, 16'd0});
      cap_in[0] = 1'b1; step(8);
      cap_in[0] = 1'b0; step(5);
      cap_in[0] = 1'b1; step(3 + FD);

      // all four channels toggle together; ch1/ch3 falling polarity, ch0/ch1 PWM
      setup(16'd1, 16'd1000, 16'd1, 4'b1111, 4'b1010, 4'b0011, 4'b1010);
      vhist.delete();
      nie = n_int_end;
      sb.push_back('{2, 1'b0, 16'd5, 16'd0, 16'd0, 16'd0});
      sb.push_back('{3, 1'b0, 16'd5, 16'd0, 16'd0, 16'd0});
      sb.push_back('{0, 1'b1, 16'd5, 16'd0, 16'd9, 16'd0});
      sb.push_back('{1, 1'b1, 16'd5, 16'd0, 16'd9, 16'd0});
      cap_in = 4'b0101; step(6);
      cap_in = 4'b1010; step(4);
      cap_in = 4'b0101; step(4 + FD);
      chk("multi_valid_events", 64'(vhist.size()), 64'd2);
      if (vhist.size() == 2) begin
         chk("multi_valid_first", 64'(vhist[0]), 64'b1100);
         chk("multi_valid_second", 64'(vhist[1]), 64'b0011);
      end
      chk("multi_done", 64'(done), 64'b1111);
      chk("multi_tim_end", 64'(tim_end), 64'd1);
      chk("multi_int_end_pulses", 64'(n_int_end - nie), 64'd1);

`ifdef ADVTIM_CAP_FILTER_EN
      setup(16'd1, 16'd100, 16'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      vhist.delete();
      cap_in[3] = 1'b1; step(3);
      cap_in[3] = 1'b0; step(10);
      chk("filt_glitch_ignored", 64'(vhist.size()), 64'd0);
      sb.push_back('{3, 1'b0, 16'd3, 16'd0, 16'd0, 16'd0});
      cap_in[3] = 1'b1; step(4);
      cap_in[3] = 1'b0; step(4);
      chk("filt_valid_not_early", 64'(valid[3]), 64'd0);
      step(1);
      chk("filt_valid_delayed", 64'(valid[3]), 64'd1);
      step(2);
`endif

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
